// File: rtl/adventure_pkg.sv
// Shared types and constants for the adventure game: room encoding,
// direction bit positions inside {n,s,e,w}, and the one-hot room decode.
package adventure_pkg;

    // Room state encoding; the enum value is also the bit position in the
    // one-hot room output.
    typedef enum logic [2:0] {
        CAVE   = 3'd0,
        TUNNEL = 3'd1,
        RIVER  = 3'd2,
        STASH  = 3'd3,
        DEN    = 3'd4,
        VAULT  = 3'd5,
        GRAVE  = 3'd6
    } room_t;

    // Bit positions of each button inside the packed {n,s,e,w} vector.
    localparam int DIR_N = 3;
    localparam int DIR_S = 2;
    localparam int DIR_E = 1;
    localparam int DIR_W = 0;

    // Width of the one-hot room output.
    localparam int ROOM_W = 7;

    // One-hot decode of a room state.
    function automatic logic [ROOM_W-1:0] room_onehot(input room_t r);
        logic [ROOM_W-1:0] oh;
        oh    = '0;
        oh[r] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/adventure_game_param_sword_keeper.sv
// Sword latch: the sword is picked up one edge after the player stands in
// the stash and is kept until reset.
module sword_keeper (
    input  logic clk,
    input  logic reset,
    input  logic in_stash,
    output logic sword
);

    logic sword_d;
    logic sword_q;

    // Sticky set: once held, only reset clears it.
    always_comb begin
        sword_d = sword_q | in_stash;
    end

    // Sword flop with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sword_q <= 1'b0;
        end else begin
            sword_q <= sword_d;
        end
    end

    assign sword = sword_q;

endmodule

// File: rtl/adventure_game_param.sv
// Adventure game top: button strobe detection, room FSM, dragon/lives
// handling and the accepted-move counter with an optional move limit.
// All visible outputs come straight from flops, so nothing on n/s/e/w
// reaches room, win or dead without passing through a clock edge.
module adventure_game_param
    import adventure_pkg::*;
#(
    parameter int LIVES      = 3,
    parameter int MOVE_LIMIT = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              n,
    input  logic              s,
    input  logic              e,
    input  logic              w,
    output logic [ROOM_W-1:0] room,
    output logic              win,
    output logic              dead,
    output logic              sword,
    output logic [3:0]        lives_left,
    output logic [7:0]        moves
);

    localparam logic [3:0] LIVES_INIT = 4'(LIVES);
    localparam logic [7:0] LIMIT      = 8'(MOVE_LIMIT);
    localparam bit         LIMIT_ON   = (MOVE_LIMIT != 0);

    logic [3:0]        dir_now;
    logic [3:0]        dir_d;
    logic [3:0]        dir_q;
    logic              one_hot;
    logic              terminal;
    logic              accept;
    logic              hit;

    room_t             room_d;
    room_t             room_q;
    logic [3:0]        lives_d;
    logic [3:0]        lives_q;
    logic [7:0]        moves_d;
    logic [7:0]        moves_q;
    logic [ROOM_W-1:0] room_oh_d;
    logic [ROOM_W-1:0] room_oh_q;
    logic              win_d;
    logic              win_q;
    logic              dead_d;
    logic              dead_q;
    logic              sword_held;

    // Strobe detection: a move needs exactly one button down this cycle
    // and no buttons down last cycle; terminal rooms freeze everything.
    always_comb begin
        dir_now  = {n, s, e, w};
        dir_d    = dir_now;
        one_hot  = (dir_now != 4'd0) && ((dir_now & (dir_now - 4'd1)) == 4'd0);
        terminal = (room_q == VAULT) || (room_q == GRAVE);
        accept   = one_hot && (dir_q == 4'd0) && !terminal;
    end

    // Next-state logic for room, lives and moves. Invalid directions
    // still count as moves; the move limit overrides everything but a win.
    always_comb begin
        room_d  = room_q;
        lives_d = lives_q;
        moves_d = moves_q;
        hit     = 1'b0;
        if (accept) begin
            moves_d = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
            case (room_q)
                CAVE: begin
                    if (dir_now[DIR_E]) room_d = TUNNEL;
                end
                TUNNEL: begin
                    if (dir_now[DIR_W])      room_d = CAVE;
                    else if (dir_now[DIR_S]) room_d = RIVER;
                end
                RIVER: begin
                    if (dir_now[DIR_N])      room_d = TUNNEL;
                    else if (dir_now[DIR_W]) room_d = STASH;
                    else if (dir_now[DIR_E]) room_d = DEN;
                end
                STASH: begin
                    if (dir_now[DIR_E]) room_d = RIVER;
                end
                DEN: begin
                    if (dir_now[DIR_N]) begin
                        if (sword_held) room_d = VAULT;
                        else            hit    = 1'b1;
                    end
                end
                default: room_d = room_q;
            endcase
            if (hit) begin
                if (lives_q > 4'd1) begin
                    lives_d = lives_q - 4'd1;
                    room_d  = CAVE;
                end else begin
                    lives_d = 4'd0;
                    room_d  = GRAVE;
                end
            end
            if (LIMIT_ON && (moves_d == LIMIT) && (room_d != VAULT)) begin
                room_d = GRAVE;
            end
        end
        room_oh_d = room_onehot(room_d);
        win_d     = (room_d == VAULT);
        dead_d    = (room_d == GRAVE);
    end

    // Game state and registered outputs, all cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q     <= 4'd0;
            room_q    <= CAVE;
            lives_q   <= LIVES_INIT;
            moves_q   <= 8'd0;
            room_oh_q <= room_onehot(CAVE);
            win_q     <= 1'b0;
            dead_q    <= 1'b0;
        end else begin
            dir_q     <= dir_d;
            room_q    <= room_d;
            lives_q   <= lives_d;
            moves_q   <= moves_d;
            room_oh_q <= room_oh_d;
            win_q     <= win_d;
            dead_q    <= dead_d;
        end
    end

    sword_keeper u_sword_keeper (
        .clk      (clk),
        .reset    (reset),
        .in_stash (room_q == STASH),
        .sword    (sword_held)
    );

    assign room       = room_oh_q;
    assign win        = win_q;
    assign dead       = dead_q;
    assign sword      = sword_held;
    assign lives_left = lives_q;
    assign moves      = moves_q;

endmodule

// File: tb/tb_adventure_game_param.sv
// Directed bench for adventure_game_param. Instance A runs with a move
// limit of 10, instance B with the limit disabled (used for the three-hit
// dragon run, which needs 12 moves, and for the saturation run).
module tb_adventure_game_param;

    localparam logic [3:0] DN = 4'b1000;
    localparam logic [3:0] DS = 4'b0100;
    localparam logic [3:0] DE = 4'b0010;
    localparam logic [3:0] DW = 4'b0001;

    localparam logic [6:0] R_CAVE   = 7'b0000001;
    localparam logic [6:0] R_TUNNEL = 7'b0000010;
    localparam logic [6:0] R_RIVER  = 7'b0000100;
    localparam logic [6:0] R_STASH  = 7'b0001000;
    localparam logic [6:0] R_DEN    = 7'b0010000;
    localparam logic [6:0] R_VAULT  = 7'b0100000;
    localparam logic [6:0] R_GRAVE  = 7'b1000000;

    logic       clk;
    logic       rst;
    logic [3:0] da;
    logic [3:0] db;

    logic [6:0] room_a, room_b;
    logic       win_a, win_b, dead_a, dead_b, sword_a, sword_b;
    logic [3:0] lives_a, lives_b;
    logic [7:0] moves_a, moves_b;

    int tests;
    int failed;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    adventure_game_param #(.LIVES(3), .MOVE_LIMIT(10)) dut_a (
        .clk        (clk),
        .reset      (rst),
        .n          (da[3]),
        .s          (da[2]),
        .e          (da[1]),
        .w          (da[0]),
        .room       (room_a),
        .win        (win_a),
        .dead       (dead_a),
        .sword      (sword_a),
        .lives_left (lives_a),
        .moves      (moves_a)
    );

    adventure_game_param #(.LIVES(3), .MOVE_LIMIT(0)) dut_b (
        .clk        (clk),
        .reset      (rst),
        .n          (db[3]),
        .s          (db[2]),
        .e          (db[1]),
        .w          (db[0]),
        .room       (room_b),
        .win        (win_b),
        .dead       (dead_b),
        .sword      (sword_b),
        .lives_left (lives_b),
        .moves      (moves_b)
    );

    // ---------------- driver tasks ----------------
    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        da  = 4'd0;
        db  = 4'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // One-cycle press on the chosen instance, followed by one idle cycle.
    task automatic strobe(input bit to_b, input logic [3:0] d);
        if (to_b) db = d;
        else      da = d;
        tick();
        da = 4'd0;
        db = 4'd0;
        tick();
    endtask

    task automatic strobe_n(input bit to_b, input logic [3:0] d, input int count);
        for (int i = 0; i < count; i++) strobe(to_b, d);
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        tests  = 0;
        failed = 0;
        rst    = 1'b1;
        da     = 4'd0;
        db     = 4'd0;
        #2;

        // Reset state, checked while reset is still asserted.
        check("rst_room",  32'(room_a),  32'(R_CAVE));
        check("rst_win",   32'(win_a),   32'd0);
        check("rst_dead",  32'(dead_a),  32'd0);
        check("rst_sword", 32'(sword_a), 32'd0);
        check("rst_lives", 32'(lives_a), 32'd3);
        check("rst_moves", 32'(moves_a), 32'd0);
        do_reset();

        // Winning path: e,s,w picks up the sword, e,e to the den, n wins.
        strobe(0, DE);
        check("win_tunnel", 32'(room_a), 32'(R_TUNNEL));
        strobe(0, DS);
        check("win_river", 32'(room_a), 32'(R_RIVER));
        strobe(0, DW);
        check("win_stash", 32'(room_a), 32'(R_STASH));
        check("win_sword_set", 32'(sword_a), 32'd1);
        strobe(0, DE);
        strobe(0, DE);
        check("win_den", 32'(room_a), 32'(R_DEN));
        check("win_sword_before_den", 32'(sword_a), 32'd1);
        strobe(0, DN);
        check("win_room",  32'(room_a),  32'(R_VAULT));
        check("win_flag",  32'(win_a),   32'd1);
        check("win_dead",  32'(dead_a),  32'd0);
        check("win_moves", 32'(moves_a), 32'd6);
        check("win_lives", 32'(lives_a), 32'd3);
        strobe(0, DS);
        check("win_term_room",  32'(room_a),  32'(R_VAULT));
        check("win_term_moves", 32'(moves_a), 32'd6);

        // Held button counts once; two buttons together never count.
        do_reset();
        da = DE;
        for (int i = 0; i < 5; i++) tick();
        da = 4'd0;
        tick();
        check("hold_room",  32'(room_a),  32'(R_TUNNEL));
        check("hold_moves", 32'(moves_a), 32'd1);
        da = DN | DE;
        tick();
        tick();
        da = 4'd0;
        tick();
        check("multi_room",  32'(room_a),  32'(R_TUNNEL));
        check("multi_moves", 32'(moves_a), 32'd1);

        // Move limit: ten blocked moves in the cave, the tenth kills.
        do_reset();
        strobe_n(0, DW, 9);
        check("lim9_room",  32'(room_a),  32'(R_CAVE));
        check("lim9_dead",  32'(dead_a),  32'd0);
        check("lim9_moves", 32'(moves_a), 32'd9);
        strobe(0, DW);
        check("lim10_room",  32'(room_a),  32'(R_GRAVE));
        check("lim10_dead",  32'(dead_a),  32'd1);
        check("lim10_moves", 32'(moves_a), 32'd10);
        check("lim10_lives", 32'(lives_a), 32'd3);
        strobe(0, DE);
        check("lim_after_moves", 32'(moves_a), 32'd10);
        check("lim_after_room",  32'(room_a),  32'(R_GRAVE));

        // Winning on exactly the limit move still wins.
        do_reset();
        strobe_n(0, DN, 4);
        strobe(0, DE);
        strobe(0, DS);
        strobe(0, DW);
        strobe(0, DE);
        strobe(0, DE);
        strobe(0, DN);
        check("limwin_room",  32'(room_a),  32'(R_VAULT));
        check("limwin_win",   32'(win_a),   32'd1);
        check("limwin_dead",  32'(dead_a),  32'd0);
        check("limwin_moves", 32'(moves_a), 32'd10);

        // Dragon hit on the limit move: grave, but the life is still lost.
        do_reset();
        strobe_n(0, DW, 6);
        strobe(0, DE);
        strobe(0, DS);
        strobe(0, DE);
        strobe(0, DN);
        check("limhit_room",  32'(room_a),  32'(R_GRAVE));
        check("limhit_dead",  32'(dead_a),  32'd1);
        check("limhit_lives", 32'(lives_a), 32'd2);
        check("limhit_moves", 32'(moves_a), 32'd10);

        // Asynchronous reset mid-game takes effect before any clock edge.
        do_reset();
        strobe(0, DE);
        strobe(0, DS);
        strobe(0, DW);
        strobe(0, DE);
        check("ar_pre_room",  32'(room_a),  32'(R_RIVER));
        check("ar_pre_sword", 32'(sword_a), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("ar_room",  32'(room_a),  32'(R_CAVE));
        check("ar_sword", 32'(sword_a), 32'd0);
        check("ar_lives", 32'(lives_a), 32'd3);
        check("ar_moves", 32'(moves_a), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Three dragon hits with no move limit.
        do_reset();
        strobe(1, DE);
        strobe(1, DS);
        strobe(1, DE);
        strobe(1, DN);
        check("hit1_room",  32'(room_b),  32'(R_CAVE));
        check("hit1_lives", 32'(lives_b), 32'd2);
        check("hit1_moves", 32'(moves_b), 32'd4);
        strobe(1, DE);
        strobe(1, DS);
        strobe(1, DE);
        strobe(1, DN);
        check("hit2_room",  32'(room_b),  32'(R_CAVE));
        check("hit2_lives", 32'(lives_b), 32'd1);
        strobe(1, DE);
        strobe(1, DS);
        strobe(1, DE);
        strobe(1, DN);
        check("hit3_room",  32'(room_b),  32'(R_GRAVE));
        check("hit3_dead",  32'(dead_b),  32'd1);
        check("hit3_lives", 32'(lives_b), 32'd0);
        check("hit3_moves", 32'(moves_b), 32'd12);
        strobe(1, DE);
        check("hit3_after_moves", 32'(moves_b), 32'd12);

        // Move counter saturates when the limit is disabled.
        do_reset();
        strobe_n(1, DW, 300);
        check("sat_moves", 32'(moves_b), 32'd255);
        check("sat_dead",  32'(dead_b),  32'd0);
        check("sat_room",  32'(room_b),  32'(R_CAVE));

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
